// File: rtl/alu_req_arbiter_if.sv
// Request/ALU/response bus of the shared-ALU arbiter; slave = arbiter, master = requesters + ALU + consumer.
// rsp_err exists only when ALU_ARB_ILLEGAL_OP_EN is defined.
interface alu_req_arbiter_if #(
  parameter int DATA_W = 32,
  parameter int OP_W   = 4
);
  logic [1:0]        req_valid;
  logic [1:0]        req_ready;
  logic [DATA_W-1:0] req_a0;
  logic [DATA_W-1:0] req_b0;
  logic [OP_W-1:0]   req_op0;
  logic [DATA_W-1:0] req_a1;
  logic [DATA_W-1:0] req_b1;
  logic [OP_W-1:0]   req_op1;
  logic [DATA_W-1:0] alu_a;
  logic [DATA_W-1:0] alu_b;
  logic [OP_W-1:0]   alu_op;
  logic [DATA_W-1:0] alu_result;
  logic              rsp_valid;
  logic              rsp_ready;
  logic              rsp_id;
  logic [DATA_W-1:0] rsp_data;
  logic              busy;
`ifdef ALU_ARB_ILLEGAL_OP_EN
  logic              rsp_err;
`endif

  modport slave (
    input  req_valid, req_a0, req_b0, req_op0, req_a1, req_b1, req_op1,
    output req_ready,
    output alu_a, alu_b, alu_op,
    input  alu_result,
    output rsp_valid, rsp_id, rsp_data, busy,
`ifdef ALU_ARB_ILLEGAL_OP_EN
    output rsp_err,
`endif
    input  rsp_ready
  );

  modport master (
    output req_valid, req_a0, req_b0, req_op0, req_a1, req_b1, req_op1,
    input  req_ready,
    input  alu_a, alu_b, alu_op,
    output alu_result,
    input  rsp_valid, rsp_id, rsp_data, busy,
`ifdef ALU_ARB_ILLEGAL_OP_EN
    input  rsp_err,
`endif
    output rsp_ready
  );
endinterface

// File: rtl/alu_req_arbiter.sv
// Two-port round-robin arbiter/sequencer for the shared ALU: IDLE -> EXEC -> RESP, one transaction at a time.
// Optional macro ALU_ARB_ILLEGAL_OP_EN: op all-ones is answered directly with rsp_err=1, rsp_data=0.
module alu_req_arbiter #(
  parameter int DATA_W = 32,
  parameter int OP_W   = 4
) (
  input logic              clk,
  input logic              rst,
  alu_req_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t            state_reg;
  logic              last_grant_reg;
  logic              cur_id_reg;
  logic [DATA_W-1:0] a_reg;
  logic [DATA_W-1:0] b_reg;
  logic [OP_W-1:0]   op_reg;
  logic [DATA_W-1:0] rsp_data_reg;
  logic              rsp_id_reg;
  logic              rsp_valid_reg;
  logic              busy_reg;
`ifdef ALU_ARB_ILLEGAL_OP_EN
  logic              rsp_err_reg;
  logic              illegal_op;
`endif

  logic [DATA_W-1:0] a_in  [2];
  logic [DATA_W-1:0] b_in  [2];
  logic [OP_W-1:0]   op_in [2];
  logic [1:0]        ready_bit;
  logic              grant;
  logic              accept;
  logic [DATA_W-1:0] sel_a;
  logic [DATA_W-1:0] sel_b;
  logic [OP_W-1:0]   sel_op;

  assign a_in[0]  = bus.req_a0;
  assign b_in[0]  = bus.req_b0;
  assign op_in[0] = bus.req_op0;
  assign a_in[1]  = bus.req_a1;
  assign b_in[1]  = bus.req_b1;
  assign op_in[1] = bus.req_op1;

  // On a tie the port that did not win last time is granted.
  always_comb begin
    grant = 1'b0;
    case (bus.req_valid)
      2'b01:   grant = 1'b0;
      2'b10:   grant = 1'b1;
      2'b11:   grant = ~last_grant_reg;
      default: grant = 1'b0;
    endcase
  end

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_ready
      assign ready_bit[gi] = (state_reg == IDLE) && bus.req_valid[gi] && (grant == 1'(gi));
    end
  endgenerate

  assign accept = |ready_bit;
  assign sel_a  = a_in[grant];
  assign sel_b  = b_in[grant];
  assign sel_op = op_in[grant];
`ifdef ALU_ARB_ILLEGAL_OP_EN
  assign illegal_op = (sel_op == {OP_W{1'b1}});
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= IDLE;
      last_grant_reg <= 1'b1;
      cur_id_reg     <= 1'b0;
      a_reg          <= '0;
      b_reg          <= '0;
      op_reg         <= '0;
      rsp_data_reg   <= '0;
      rsp_id_reg     <= 1'b0;
      rsp_valid_reg  <= 1'b0;
      busy_reg       <= 1'b0;
`ifdef ALU_ARB_ILLEGAL_OP_EN
      rsp_err_reg    <= 1'b0;
`endif
    end else begin
      case (state_reg)
        IDLE: begin
          if (accept) begin
            cur_id_reg     <= grant;
            last_grant_reg <= grant;
            busy_reg       <= 1'b1;
`ifdef ALU_ARB_ILLEGAL_OP_EN
            if (illegal_op) begin
              // Answer immediately; the ALU operand registers keep their old values.
              rsp_data_reg  <= '0;
              rsp_id_reg    <= grant;
              rsp_err_reg   <= 1'b1;
              rsp_valid_reg <= 1'b1;
              state_reg     <= RESP;
            end else begin
              a_reg       <= sel_a;
              b_reg       <= sel_b;
              op_reg      <= sel_op;
              rsp_err_reg <= 1'b0;
              state_reg   <= EXEC;
            end
`else
            a_reg     <= sel_a;
            b_reg     <= sel_b;
            op_reg    <= sel_op;
            state_reg <= EXEC;
`endif
          end
        end
        EXEC: begin
          rsp_data_reg  <= bus.alu_result;
          rsp_id_reg    <= cur_id_reg;
          rsp_valid_reg <= 1'b1;
          state_reg     <= RESP;
        end
        RESP: begin
          if (bus.rsp_ready) begin
            rsp_valid_reg <= 1'b0;
            busy_reg      <= 1'b0;
            state_reg     <= IDLE;
          end
        end
        default: begin
          rsp_valid_reg <= 1'b0;
          busy_reg      <= 1'b0;
          state_reg     <= IDLE;
        end
      endcase
    end
  end

  assign bus.req_ready = ready_bit;
  assign bus.alu_a     = a_reg;
  assign bus.alu_b     = b_reg;
  assign bus.alu_op    = op_reg;
  assign bus.rsp_valid = rsp_valid_reg;
  assign bus.rsp_id    = rsp_id_reg;
  assign bus.rsp_data  = rsp_data_reg;
  assign bus.busy      = busy_reg;
`ifdef ALU_ARB_ILLEGAL_OP_EN
  assign bus.rsp_err   = rsp_err_reg;
`endif

endmodule

// File: tb/tb_alu_req_arbiter.sv
// Scoreboard bench for alu_req_arbiter: accepts push expected responses, the response monitor pops and compares.
module tb_alu_req_arbiter;
  localparam int DATA_W = 32;
  localparam int OP_W   = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  alu_req_arbiter_if #(.DATA_W(DATA_W), .OP_W(OP_W)) bus ();

  alu_req_arbiter #(.DATA_W(DATA_W), .OP_W(OP_W)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  // Reference ALU sitting on the bus: add, sub, and, or, xor; anything else returns 0.
  function automatic logic [31:0] alu_f(input logic [31:0] a, input logic [31:0] b, input logic [3:0] op);
    case (op)
      4'd0:    return a + b;
      4'd1:    return a - b;
      4'd2:    return a & b;
      4'd3:    return a | b;
      4'd4:    return a ^ b;
      default: return 32'd0;
    endcase
  endfunction

  assign bus.alu_result = alu_f(bus.alu_a, bus.alu_b, bus.alu_op);

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  typedef struct {
    logic        id;
    logic [31:0] data;
    logic        err;
    int          lat;
    int          acc;
  } exp_t;

  exp_t sb[$];
  int   grant_log[$];
  exp_t e;
  exp_t n;
  logic rv_prev = 1'b0;

  always @(negedge clk) begin
    if (rst) begin
      rv_prev = 1'b0;
    end else begin
      check("ready_onehot", 64'($countones(bus.req_ready) <= 1), 64'd1);
      if (bus.rsp_valid) begin
        if (sb.size() == 0) begin
          check("spurious_rsp", 64'(bus.rsp_valid), 64'd0);
        end else begin
          if (!rv_prev) check("latency", 64'(cyc - sb[0].acc), 64'(sb[0].lat));
          if (bus.rsp_ready) begin
            e = sb.pop_front();
            check("rsp_data", 64'(bus.rsp_data), 64'(e.data));
            check("rsp_id", 64'(bus.rsp_id), 64'(e.id));
`ifdef ALU_ARB_ILLEGAL_OP_EN
            check("rsp_err", 64'(bus.rsp_err), 64'(e.err));
`endif
            $display("rsp id=%0d data=%08h (cycle %0d)", bus.rsp_id, bus.rsp_data, cyc);
          end
        end
      end
      for (int i = 0; i < 2; i++) begin
        if (bus.req_valid[i] && bus.req_ready[i]) begin
          logic [31:0] a;
          logic [31:0] b;
          logic [3:0]  op;
          a  = (i == 1) ? bus.req_a1  : bus.req_a0;
          b  = (i == 1) ? bus.req_b1  : bus.req_b0;
          op = (i == 1) ? bus.req_op1 : bus.req_op0;
          n.id   = 1'(i);
          n.data = alu_f(a, b, op);
          n.acc  = cyc;
`ifdef ALU_ARB_ILLEGAL_OP_EN
          n.err  = (op == 4'hF);
          n.lat  = (op == 4'hF) ? 1 : 2;
`else
          n.err  = 1'b0;
          n.lat  = 2;
`endif
          sb.push_back(n);
          grant_log.push_back(i);
          $display("req port=%0d a=%08h b=%08h op=%0h (cycle %0d)", i, a, b, op, cyc);
        end
      end
      rv_prev = bus.rsp_valid;
    end
  end

  task automatic check_reset_vals(input string pfx);
    check({pfx, "_req_ready"}, 64'(bus.req_ready), 64'd0);
    check({pfx, "_rsp_valid"}, 64'(bus.rsp_valid), 64'd0);
    check({pfx, "_rsp_id"},    64'(bus.rsp_id),    64'd0);
    check({pfx, "_rsp_data"},  64'(bus.rsp_data),  64'd0);
    check({pfx, "_alu_a"},     64'(bus.alu_a),     64'd0);
    check({pfx, "_alu_b"},     64'(bus.alu_b),     64'd0);
    check({pfx, "_alu_op"},    64'(bus.alu_op),    64'd0);
    check({pfx, "_busy"},      64'(bus.busy),      64'd0);
`ifdef ALU_ARB_ILLEGAL_OP_EN
    check({pfx, "_rsp_err"},   64'(bus.rsp_err),   64'd0);
`endif
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.req_valid = 2'b00;
    @(posedge clk); #1;
    check_reset_vals("rst");
    sb.delete();
    rst = 1'b0;
  endtask

  task automatic set_payload(input int p, input logic [31:0] a, input logic [31:0] b, input logic [3:0] op);
    if (p == 0) begin
      bus.req_a0 = a; bus.req_b0 = b; bus.req_op0 = op;
    end else begin
      bus.req_a1 = a; bus.req_b1 = b; bus.req_op1 = op;
    end
  endtask

  // Returns at posedge+1 right after the accepting edge, valid already dropped.
  task automatic send(input int p, input logic [31:0] a, input logic [31:0] b, input logic [3:0] op);
    bit ok;
    ok = 1'b0;
    set_payload(p, a, b, op);
    bus.req_valid[p] = 1'b1;
    for (int k = 0; k < 30 && !ok; k++) begin
      @(negedge clk);
      ok = bus.req_ready[p];
      @(posedge clk); #1;
    end
    bus.req_valid[p] = 1'b0;
    if (!ok) check("send_timeout", 64'd0, 64'd1);
  endtask

  task automatic wait_rsp();
    int k;
    for (k = 0; k < 20 && !bus.rsp_valid; k++) begin
      @(posedge clk); #1;
    end
    if (!bus.rsp_valid) check("wait_rsp_timeout", 64'd0, 64'd1);
  endtask

  task automatic wait_drain();
    bit done;
    done = 1'b0;
    bus.rsp_ready = 1'b1;
    for (int k = 0; k < 30 && !done; k++) begin
      @(posedge clk); #1;
      done = !bus.busy && (sb.size() == 0);
    end
    if (!done) check("drain_timeout", 64'd0, 64'd1);
  endtask

  task automatic wait_grants(input int target);
    int k;
    for (k = 0; k < 60 && grant_log.size() < target; k++) begin
      @(posedge clk); #1;
    end
    if (grant_log.size() < target) check("grant_timeout", 64'(grant_log.size()), 64'(target));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int g0;
    rst = 1'b1;
    bus.req_valid = 2'b00;
    bus.rsp_ready = 1'b0;
    set_payload(0, 0, 0, 0);
    set_payload(1, 0, 0, 0);
    repeat (2) @(posedge clk);
    #1;
    check_reset_vals("init");
    rst = 1'b0;

    // Single add on port 0 with a response consumer always ready.
    bus.rsp_ready = 1'b1;
    set_payload(0, 32'd5, 32'd7, 4'd0);
    bus.req_valid = 2'b01;
    #1;
    check("t1_ready_same_cycle", 64'(bus.req_ready), 64'd1);
    @(posedge clk); #1;
    bus.req_valid = 2'b00;
    check("t1_busy_exec", 64'(bus.busy), 64'd1);
    check("t1_no_rsp_exec", 64'(bus.rsp_valid), 64'd0);
    check("t1_alu_a", 64'(bus.alu_a), 64'd5);
    check("t1_alu_b", 64'(bus.alu_b), 64'd7);
    @(posedge clk); #1;
    check("t1_rsp_valid", 64'(bus.rsp_valid), 64'd1);
    check("t1_rsp_data", 64'(bus.rsp_data), 64'd12);
    check("t1_rsp_id", 64'(bus.rsp_id), 64'd0);
    check("t1_busy_resp", 64'(bus.busy), 64'd1);
    @(posedge clk); #1;
    check("t1_busy_idle", 64'(bus.busy), 64'd0);
    check("t1_rsp_done", 64'(bus.rsp_valid), 64'd0);
    wait_drain();

    // Tie from reset: grants alternate starting with port 0.
    do_reset();
    bus.rsp_ready = 1'b1;
    set_payload(0, 32'd10, 32'd3, 4'd1);
    set_payload(1, 32'hF0F0, 32'hFF00, 4'd2);
    g0 = grant_log.size();
    bus.req_valid = 2'b11;
    wait_grants(g0 + 4);
    bus.req_valid = 2'b00;
    for (int k = 0; k < 4; k++) begin
      if (grant_log.size() > g0 + k) check("tie_grant", 64'(grant_log[g0 + k]), 64'(k % 2));
    end
    wait_drain();

    // Backpressure in RESP while port 1 waits.
    bus.rsp_ready = 1'b0;
    send(0, 32'd100, 32'd1, 4'd0);
    wait_rsp();
    set_payload(1, 32'h1234_5678, 32'h0F0F_0F0F, 4'd4);
    bus.req_valid = 2'b10;
    for (int k = 0; k < 5; k++) begin
      check("bp_rsp_valid", 64'(bus.rsp_valid), 64'd1);
      check("bp_rsp_data", 64'(bus.rsp_data), 64'd101);
      check("bp_rsp_id", 64'(bus.rsp_id), 64'd0);
      check("bp_req_ready", 64'(bus.req_ready), 64'd0);
      @(posedge clk); #1;
    end
    bus.rsp_ready = 1'b1;
    #1;
    check("bp_no_accept_on_rsp_hs", 64'(bus.req_ready), 64'd0);
    @(posedge clk); #1;
    check("bp_accept_after_hs", 64'(bus.req_ready), 64'd2);
    @(posedge clk); #1;
    bus.req_valid = 2'b00;
    check("bp_busy_after_accept", 64'(bus.busy), 64'd1);
    wait_drain();

    // Reset while in EXEC drops the transaction.
    send(1, 32'd2, 32'd3, 4'd0);
    check("rst_mid_in_exec", 64'(bus.busy), 64'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    check_reset_vals("rst_mid");
    sb.delete();
    rst = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(posedge clk); #1;
      check("rst_mid_no_rsp", 64'(bus.rsp_valid), 64'd0);
    end

    // Port 1 withdraws during RESP; last_grant must remain 0 afterwards.
    bus.rsp_ready = 1'b0;
    send(0, 32'd8, 32'd9, 4'd3);
    wait_rsp();
    set_payload(1, 32'hDEAD, 32'hBEEF, 4'd0);
    bus.req_valid = 2'b10;
    repeat (2) begin
      @(posedge clk); #1;
      check("wd_req_ready", 64'(bus.req_ready), 64'd0);
    end
    bus.req_valid = 2'b00;
    g0 = grant_log.size();
    wait_drain();
    check("wd_no_grant", 64'(grant_log.size()), 64'(g0));
    set_payload(0, 32'd1, 32'd1, 4'd0);
    set_payload(1, 32'd6, 32'd3, 4'd1);
    bus.req_valid = 2'b11;
    wait_grants(g0 + 1);
    bus.req_valid = 2'b00;
    if (grant_log.size() > g0) check("wd_tie_goes_to_1", 64'(grant_log[g0]), 64'd1);
    wait_drain();

    // All-ones opcode on port 0.
    bus.rsp_ready = 1'b1;
    send(0, 32'd3, 32'd4, 4'hF);
`ifdef ALU_ARB_ILLEGAL_OP_EN
    check("ill_rsp_valid_lat1", 64'(bus.rsp_valid), 64'd1);
    check("ill_rsp_err", 64'(bus.rsp_err), 64'd1);
    check("ill_rsp_data", 64'(bus.rsp_data), 64'd0);
    check("ill_alu_a_kept", 64'(bus.alu_a), 64'd6);
`else
    check("ill_no_rsp_lat1", 64'(bus.rsp_valid), 64'd0);
    @(posedge clk); #1;
    check("ill_rsp_valid_lat2", 64'(bus.rsp_valid), 64'd1);
    check("ill_rsp_data", 64'(bus.rsp_data), 64'd0);
`endif
    check("ill_rsp_id", 64'(bus.rsp_id), 64'd0);
    wait_drain();

    // Random legal traffic with random consumer stalls.
    for (int k = 0; k < 8; k++) begin
      bus.rsp_ready = 1'($urandom_range(0, 1));
      send(int'($urandom_range(0, 1)), $urandom, $urandom, 4'($urandom_range(0, 4)));
      repeat ($urandom_range(0, 3)) begin
        @(posedge clk); #1;
      end
      wait_drain();
    end

    check("final_sb_empty", 64'(sb.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
